// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between a binary source and the BCD converter.
// master drives the request and display blank; slave is the converter side.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  blank;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (output start, bin_in, blank, input busy, done, ovf, bcd_out);
    modport slave  (input start, bin_in, blank, output busy, done, ovf, bcd_out);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional LEADING_ZERO_BLANK_EN stores leading zero digits as 4'hF on load.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]       state;
    logic [BIN_W-1:0] sr;
    logic [SW-1:0]    s;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    s_nxt;
    logic [SW-1:0]    res;
    logic [SW-1:0]    res_ld;
    logic [CW-1:0]    cnt;
    logic             acc;
    logic             out_bit;
    logic             done_r;
    logic             ovf_r;

    // Add-3 correction on every digit in parallel, before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (s[4*g +: 4] >= 4'd5) ? s[4*g +: 4] + 4'd3 : s[4*g +: 4];
    end

    assign s_nxt   = {adj[SW-2:0], sr[BIN_W-1]};
    assign out_bit = adj[SW-1];

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_seen;

    // Digit 0 is never blanked so a zero result still shows a single 0.
    always_comb begin
        lz_seen = 1'b0;
        res_ld  = s_nxt;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (s_nxt[4*i +: 4] != 4'd0)
                lz_seen = 1'b1;
            else if (!lz_seen)
                res_ld[4*i +: 4] = 4'hF;
        end
    end
`else
    assign res_ld = s_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            s      <= '0;
            cnt    <= '0;
            acc    <= 1'b0;
            res    <= '0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr    <= bus.bin_in;
                        s     <= '0;
                        cnt   <= CW'(BIN_W - 1);
                        acc   <= 1'b0;
                        state <= CONV;
                    end
                end
                default: begin
                    sr  <= sr << 1;
                    s   <= s_nxt;
                    acc <= acc | out_bit;
                    // Bits pushed out of the top digit mean the value exceeded the digit range.
                    if (cnt == '0) begin
                        res    <= res_ld;
                        ovf_r  <= acc | out_bit;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = (state == CONV);
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.bcd_out = bus.blank ? {SW{1'b1}} : res;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (5 and 4 digits) fed identical stimulus,
// checked every cycle against a transaction-level arithmetic model.
module tb_bin_to_bcd_seq;
    localparam int W = 16;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 0;

    bin_to_bcd_seq_if #(.BIN_W(W), .DIGITS(5)) ifa ();
    bin_to_bcd_seq_if #(.BIN_W(W), .DIGITS(4)) ifb ();

    bin_to_bcd_seq #(.BIN_W(W), .DIGITS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bin_to_bcd_seq #(.BIN_W(W), .DIGITS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifb.start  = ifa.start;
    assign ifb.bin_in = ifa.bin_in;
    assign ifb.blank  = ifa.blank;

    function automatic longint pow10(input int d);
        longint p = 1;
        repeat (d) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v mod 10^d, with optional leading-zero blanking.
    function automatic logic [19:0] bcd_of(input longint v, input int d, input bit lzb);
        logic [19:0] r = '0;
        longint x = v % pow10(d);
        bit seen = 0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        if (lzb) begin
            for (int i = d - 1; i >= 1; i--) begin
                if (r[4*i +: 4] != 4'd0) seen = 1;
                else if (!seen) r[4*i +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a start seen while idle yields its result W cycles later.
    int          m_rem;
    longint      m_val;
    logic [19:0] m_res_a, m_res_b;
    logic        m_ovf_a, m_ovf_b, m_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem   <= 0;
            m_val   <= 0;
            m_res_a <= '0;
            m_res_b <= '0;
            m_ovf_a <= 1'b0;
            m_ovf_b <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (ifa.start) begin
                    m_rem <= W;
                    m_val <= longint'(ifa.bin_in);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_res_a <= bcd_of(m_val, 5, LZB);
                    m_res_b <= bcd_of(m_val, 4, LZB);
                    m_ovf_a <= (m_val >= pow10(5));
                    m_ovf_b <= (m_val >= pow10(4));
                    m_done  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_a", 32'(ifa.busy), 32'(m_rem != 0));
            chk("done_a", 32'(ifa.done), 32'(m_done));
            chk("ovf_a",  32'(ifa.ovf),  32'(m_ovf_a));
            chk("bcd_a",  32'(ifa.bcd_out), 32'(ifa.blank ? 20'hFFFFF : m_res_a));
            chk("busy_b", 32'(ifb.busy), 32'(m_rem != 0));
            chk("done_b", 32'(ifb.done), 32'(m_done));
            chk("ovf_b",  32'(ifb.ovf),  32'(m_ovf_b));
            chk("bcd_b",  32'(ifb.bcd_out), 32'(ifb.blank ? 16'hFFFF : m_res_b[15:0]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [W-1:0] v);
        ifa.start  = 1'b1;
        ifa.bin_in = v;
        cyc();
        ifa.start  = 1'b0;
        ifa.bin_in = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        forever begin
            cyc();
            n++;
            if (ifa.done || n >= 40) break;
        end
        chk("done_seen", 32'(ifa.done), 32'd1);
    endtask

    int n;
    int dcount;

    initial begin
        rst_n      = 1'b0;
        ifa.start  = 1'b0;
        ifa.bin_in = '0;
        ifa.blank  = 1'b0;

        // Pin the reference model to hand-computed values.
        chk("model_65535", 32'(bcd_of(65535, 5, 0)), 32'h65535);
        chk("model_12345_d4", 32'(bcd_of(12345, 4, 0)), 32'h2345);
        chk("model_0_lzb", 32'(bcd_of(0, 5, 1)), 32'hFFFF0);
        chk("model_1234_lzb", 32'(bcd_of(1234, 5, 1)), 32'hF1234);

        repeat (3) cyc();
        chk_en = 1;
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_bcd", 32'(ifa.bcd_out), 32'd0);
        rst_n = 1'b1;
        cyc();

        go(16'd65535);
        wait_done(n);
        chk("t1_latency", 32'(n), 32'd16);
        chk("t1_bcd", 32'(ifa.bcd_out), 32'h65535);
        chk("t1_ovf", 32'(ifa.ovf), 32'd0);

        go(16'd0);
        wait_done(n);
        chk("t2_zero", 32'(ifa.bcd_out), LZB ? 32'hFFFF0 : 32'h00000);
        go(16'd1234);
        wait_done(n);
        chk("t2_b2b_latency", 32'(n), 32'd16);
        chk("t2_1234", 32'(ifa.bcd_out), LZB ? 32'hF1234 : 32'h01234);

        go(16'd999);
        repeat (4) cyc();
        ifa.start  = 1'b1;
        ifa.bin_in = 16'd7;
        cyc();
        ifa.start  = 1'b0;
        wait_done(n);
        chk("t3_999", 32'(ifa.bcd_out), LZB ? 32'hFF999 : 32'h00999);
        dcount = 0;
        repeat (20) begin cyc(); if (ifa.done) dcount++; end
        chk("t3_single_done", 32'(dcount), 32'd0);

        go(16'd12345);
        wait_done(n);
        chk("t4_bcd_d4", 32'(ifb.bcd_out), 32'h2345);
        chk("t4_ovf_d4", 32'(ifb.ovf), 32'd1);
        go(16'd42);
        wait_done(n);
        chk("t4_42_d4", 32'(ifb.bcd_out), LZB ? 32'hFF42 : 32'h0042);
        chk("t4_ovf_clr", 32'(ifb.ovf), 32'd0);

        ifa.blank = 1'b1;
        go(16'd500);
        wait_done(n);
        chk("t5_latency", 32'(n), 32'd16);
        chk("t5_blank", 32'(ifa.bcd_out), 32'hFFFFF);
        ifa.blank = 1'b0;
        #1;
        chk("t5_unblank", 32'(ifa.bcd_out), LZB ? 32'hFF500 : 32'h00500);

        go(16'd4321);
        repeat (7) cyc();
        rst_n = 1'b0;
        cyc();
        chk("t6_busy", 32'(ifa.busy), 32'd0);
        chk("t6_bcd", 32'(ifa.bcd_out), 32'd0);
        rst_n = 1'b1;
        dcount = 0;
        repeat (20) begin cyc(); if (ifa.done) dcount++; end
        chk("t6_no_done", 32'(dcount), 32'd0);
        go(16'd4321);
        wait_done(n);
        chk("t6_after", 32'(ifa.bcd_out), LZB ? 32'hF4321 : 32'h04321);

        // Random traffic: start pulses at any time, random blank, rare resets.
        repeat (4000) begin
            ifa.start  = ($urandom_range(0, 3) == 0);
            ifa.bin_in = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            ifa.blank  = ($urandom_range(0, 7) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n     = 1'b1;
        ifa.start = 1'b0;
        ifa.blank = 1'b0;
        repeat (20) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
